// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch front end and its decode consumer.
package ifu_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] EBREAK_INSN = 32'h00100073;
    localparam logic [4:0]  OP5_JAL     = 5'b11011;

    // One buffered fetch: the instruction word together with the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // JAL J-type immediate, sign-extended to 32 bits (also used by decode).
    function automatic logic signed [31:0] imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bundle of the fetch unit's memory port, redirect input and decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface ifu_prefetch_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             ebreak_seen;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, ebreak_seen,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, ebreak_seen,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/ifu_fifo.sv
// Parametrised synchronous FIFO with flush and a combinational head read.
// The writer guarantees no push into a full FIFO unless a pop happens in the
// same cycle; flush wins over push and pop.
module ifu_fifo #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap at DEPTH (naturally a power-of-two wrap for the default sizes).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointer/occupancy; flush empties the queue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: pipelined request/response memory port,
// in-order prefetch FIFO toward decode, flush on redirect with stale-response discard.
// Optional macro IFU_JAL_PREDICT_EN: follow JAL targets internally without a FIFO flush.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifu_prefetch_if.master bus
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OW  = CW + 1;
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    discard_q,  discard_d;

    logic [CW-1:0]        count;
    logic [TCW-1:0]       tag_count;
    logic [WIDTH-1:0]     tag_head;
    logic [2*WIDTH-1:0]   head_entry;
    logic [OW-1:0]        occupancy;

    logic req_fire;
    logic rsp_accept;
    logic rsp_enq;
    logic instr_pop;
    logic jal_take;

    // Slots already claimed: buffered entries plus responses that will be kept.
    assign occupancy  = OW'(count) + OW'(inflight_q) - OW'(discard_q);

    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                                && (inflight_q < CW'(MAX_OUTSTANDING))
                                && (occupancy < OW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    // Responses with nothing outstanding are ignored entirely.
    assign rsp_accept = bus.imem_rsp_valid && (inflight_q != '0);
    assign rsp_enq    = rsp_accept && !bus.redirect_valid && (discard_q == '0);

    assign bus.instr_valid = (count != '0) && !bus.redirect_valid;
    assign bus.instr_pc    = head_entry[2*WIDTH-1:WIDTH];
    assign bus.instr       = head_entry[WIDTH-1:0];
    assign bus.ebreak_seen = bus.instr_valid && (bus.instr == WIDTH'(EBREAK_INSN));
    assign instr_pop       = bus.instr_valid && bus.instr_ready;

`ifdef IFU_JAL_PREDICT_EN
    assign jal_take = rsp_enq && (bus.imem_rsp_data[6:2] == OP5_JAL);
`else
    assign jal_take = 1'b0;
`endif

    // Next fetch PC, in-flight and discard counts; external redirect has final say.
    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + WIDTH'(4) : fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_accept);
        discard_d  = (rsp_accept && discard_q != '0) ? discard_q - 1'b1 : discard_q;
        if (jal_take) begin
            // Everything still outstanding (including a request fired this cycle) is wrong-path.
            fetch_pc_d = (tag_head + WIDTH'(imm_j(bus.imem_rsp_data[31:0]))) & ~WIDTH'(3);
            discard_d  = inflight_d;
        end
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~WIDTH'(3);
            discard_d  = inflight_d;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // PC tags of outstanding requests; responses return in order, so the head matches.
    ifu_fifo #(
        .DW    (WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_accept),
        .head_data (tag_head),
        .count     (tag_count)
    );

    // Instruction buffer toward decode, flushed on redirect.
    ifu_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (rsp_enq),
        .push_data ({tag_head, bus.imem_rsp_data}),
        .pop       (instr_pop),
        .head_data (head_entry),
        .count     (count)
    );

    // Simulation checks: no unsolicited responses, tag queue tracks in-flight count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rsp_valid && inflight_q == '0));
            assert (CW'(tag_count) == inflight_q);
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch with a fixed-latency in-order memory model.
module tb_ifu_prefetch;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.WIDTH(32)) bus ();

    ifu_prefetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int          lat          = 1;
    int          edge_cnt     = 0;
    int          fire_cnt     = 0;
    logic [31:0] special_addr = 32'h0000_0001;
    logic [31:0] special_word = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == special_addr) ? special_word : 32'h0000_0013;
    endfunction

    // Memory: capture accepted requests on the rising edge (pre-update values).
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            pend.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{mem_word(bus.imem_req_addr), edge_cnt + lat});
            fire_cnt++;
        end
    end

    // Memory: present a response half a cycle before the edge that samples it.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && pend.size() > 0 && pend[0].due == edge_cnt + 1) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset for three cycles, release on a falling edge; returns just after release.
    task automatic do_reset(input int l, input logic rdy);
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = rdy;
        lat                = l;
        repeat (3) @(negedge clk);
        fire_cnt = 0;
        rst      = 1'b0;
        #1;
    endtask

    // Wait (bounded) for a valid head and check its PC and word.
    task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_word);
        int n = 0;
        while (!bus.instr_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_pc"}, bus.instr_pc, exp_pc);
        check({tag, "_word"}, bus.instr, exp_word);
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_ebreak", 32'(bus.ebreak_seen), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);

        // Streaming with one-cycle memory
        do_reset(1, 1'b1);
        check("t1_req_valid0", 32'(bus.imem_req_valid), 32'd1);
        check("t1_req_addr0", bus.imem_req_addr, 32'h8000_0000);
        check("t1_valid0", 32'(bus.instr_valid), 32'd0);
        @(negedge clk); #1;
        check("t1_valid1", 32'(bus.instr_valid), 32'd0);
        check("t1_req_addr1", bus.imem_req_addr, 32'h8000_0004);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("t1_valid_c%0d", k), 32'(bus.instr_valid), 32'd1);
            check($sformatf("t1_pc_c%0d", k), bus.instr_pc, 32'h8000_0000 + 32'(4 * k));
            check($sformatf("t1_word_c%0d", k), bus.instr, 32'h0000_0013);
        end

        // Decode stalled: FIFO fills to DEPTH, then drains in order
        do_reset(1, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        check("t2_full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t2_full_fires", 32'(fire_cnt), 32'd4);
        check("t2_full_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_full_pc", bus.instr_pc, 32'h8000_0000);
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_drain_valid%0d", k), 32'(bus.instr_valid), 32'd1);
            check($sformatf("t2_drain_pc%0d", k), bus.instr_pc, 32'h8000_0000 + 32'(4 * k));
            if (k == 1) begin
                check("t2_resume_valid", 32'(bus.imem_req_valid), 32'd1);
                check("t2_resume_addr", bus.imem_req_addr, 32'h8000_0010);
            end
            @(negedge clk); #1;
        end

        // Redirect with two requests in flight on a three-cycle memory
        do_reset(3, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("t3_inflight_block", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        #1;
        check("t3_redir_suppress", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("t3_new_addr", bus.imem_req_addr, 32'h8000_0100);
        check("t3_still_full", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk); #1;
        check("t3_req_after_drop", 32'(bus.imem_req_valid), 32'd1);
        check("t3_req_addr", bus.imem_req_addr, 32'h8000_0100);
        check("t3_no_stale", 32'(bus.instr_valid), 32'd0);
        wait_valid("t3_first", 32'h8000_0100, 32'h0000_0013);

        // Redirect coinciding with a response and a dequeue
        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("t4_pre_valid", 32'(bus.instr_valid), 32'd1);
        check("t4_pre_pc", bus.instr_pc, 32'h8000_0004);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        #1;
        check("t4_redir_valid", 32'(bus.instr_valid), 32'd0);
        check("t4_redir_req", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_flushed", 32'(bus.instr_valid), 32'd0);
        check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);
        wait_valid("t4_first", 32'h8000_0200, 32'h0000_0013);

        // EBREAK detection on the head only
        special_addr = 32'h8000_0004;
        special_word = EBREAK_INSN;
        do_reset(1, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        check("t5_head0_pc", bus.instr_pc, 32'h8000_0000);
        check("t5_head0_ebreak", 32'(bus.ebreak_seen), 32'd0);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        check("t5_head1_pc", bus.instr_pc, 32'h8000_0004);
        check("t5_head1_word", bus.instr, EBREAK_INSN);
        check("t5_head1_ebreak", 32'(bus.ebreak_seen), 32'd1);
        @(negedge clk); #1;
        check("t5_hold_ebreak", 32'(bus.ebreak_seen), 32'd1);
        bus.redirect_valid = 1'b1;
        #1;
        check("t5_redir_ebreak", 32'(bus.ebreak_seen), 32'd0);
        bus.redirect_valid = 1'b0;
        #1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        check("t5_popped_pc", bus.instr_pc, 32'h8000_0008);
        check("t5_popped_ebreak", 32'(bus.ebreak_seen), 32'd0);
        special_addr = 32'h0000_0001;

`ifdef IFU_JAL_PREDICT_EN
        // Internal JAL follow: jal x0,+16 at the reset PC
        special_addr = 32'h8000_0000;
        special_word = 32'h0100_006F;
        do_reset(1, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("t6_req_addr", bus.imem_req_addr, 32'h8000_0010);
        check("t6_jal_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_jal_pc", bus.instr_pc, 32'h8000_0000);
        check("t6_jal_word", bus.instr, 32'h0100_006F);
        @(negedge clk); #1;
        check("t6_discarded", 32'(bus.instr_valid), 32'd0);
        wait_valid("t6_target", 32'h8000_0010, 32'h0000_0013);
        special_addr = 32'h0000_0001;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Sequential instruction-fetch front end for the next CPU generation. Replaces the combinational, zero-latency memory read with a pipelined request/response memory port.
- Issues in-order word fetches ahead of execution into a parametrised FIFO and hands instructions plus their PCs to decode with valid/ready.
- Flushes on redirect (branch/jump/trap) and discards stale in-flight responses.

Parameters:
- WIDTH, 32, address/instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum in-flight memory requests; 1..DEPTH.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WIDTH  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in request order; no backpressure
- imem_rsp_data  in  WIDTH  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  WIDTH  new fetch PC; bits [1:0] ignored
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode consumes head
- instr  out  WIDTH  head instruction
- instr_pc  out  WIDTH  head PC
- ebreak_seen  out  1  head is 32'h00100073 and instr_valid

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, count=0, inflight=0, discard=0, instr_valid=0, imem_req_valid=0, ebreak_seen=0. Mid-operation reset drops all entries and in-flight accounting immediately.
- Request issue:
  - imem_req_valid = !redirect_valid && inflight<MAX_OUTSTANDING && (count+inflight-discard)<DEPTH.
  - imem_req_addr = fetch_pc.
  - On req fire: fetch_pc += 4 (wraps modulo 2^WIDTH), inflight++. A request is pushed with its address into a pc-tag queue of depth MAX_OUTSTANDING.
- Response handling:
  - On imem_rsp_valid, inflight--.
  - If discard>0: discard--, data dropped, tag popped.
  - Else {data, tag} is written to the FIFO, count++.
  - The space check guarantees the FIFO never overflows. An unsolicited response (inflight=0) is ignored; assertion in simulation.
- Dequeue: on instr_valid && instr_ready, the head is popped, count--. Enqueue and dequeue in the same cycle leave count unchanged. Full FIFO with a simultaneous pop accepts the response.
- Latency: first request in the cycle after reset release. With zero-latency memory (rsp one cycle after req), instr_valid rises 2 cycles after reset release. Sustained throughput is 1 instr/cycle when MAX_OUTSTANDING ≥ memory latency.
- Redirect (highest priority):
  - FIFO is cleared (count=0); any same-cycle pop is void.
  - discard = inflight after this cycle's response accounting. A same-cycle response is dropped.
  - fetch_pc = {redirect_pc[WIDTH-1:2],2'b00}. The request in the redirect cycle is suppressed; the first new request is issued the next cycle.
  - Back-to-back redirects: the last one wins; discard stays consistent.
- instr_valid = (count≠0) && !redirect_valid. instr and instr_pc are stable while valid && !ready.
- Pointers are log2(DEPTH) bits and wrap naturally. Counters are $clog2(DEPTH+1) bits.

Optional Feature:
- Macro IFU_JAL_PREDICT_EN.
- With the macro:
  - An accepted, non-discarded response whose opcode[6:2]=5'b11011 (JAL) is enqueued normally.
  - Internally redirects fetch_pc to tag + immJ, where immJ = sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
  - Marks all later in-flight requests as discard.
  - The FIFO is not flushed.
  - External redirect_valid overrides in the same cycle.
- Without the macro: straight-line sequential fetch only; JAL is handled by an external redirect.

Decomposition:
- Shared package ifu_pkg holds:
  - EBREAK_INSN constant 32'h00100073.
  - OP5_JAL constant 5'b11011.
  - fetch_entry_t typedef {pc, instr}.
  - The immJ extraction function, reused by decode.
- One natural sub-module: ifu_fifo, a parametrised synchronous FIFO with flush, instantiated for the instruction buffer (DEPTH) and for the pc-tag queue (MAX_OUTSTANDING).

Test Plan:
- Reset release, memory returns 32'h00000013 one cycle after each req, instr_ready=1 → instr_pc sequence 8000_0000, 8000_0004, 8000_0008…; first instr_valid 2 cycles after release; one instr per cycle.
- instr_ready=0 held → exactly DEPTH=4 responses enqueued, imem_req_valid=0 thereafter, no overflow; release ready → 4 entries drain in order, then fetch resumes at 8000_0010.
- Memory latency 3 cycles, 2 requests in flight, redirect_pc=8000_0102 asserted → next req addr 8000_0100; both stale responses dropped; first instr_pc = 8000_0100.
- Redirect in the same cycle as a response and a dequeue → response dropped, head not consumed, count=0 next cycle, instr_valid=0.
- Head word 32'h00100073 → ebreak_seen=1 only while it is the valid head; 0 after pop.
- (IFU_JAL_PREDICT_EN) Response 32'h0100006F (jal x0,+16) at 8000_0000 → next req addr 8000_0010; response for 8000_0004 discarded; instr_pc sequence 8000_0000, 8000_0010.
